// File: rtl/flag_pkg.sv
// Shared constants for the condition-code unit: flag bit positions,
// branch-type encodings and the default condition-code width.
package flag_pkg;

    // Default condition-code width (Z, N, C)
    localparam int FLAG_W = 3;

    // Bit positions inside the condition-code register
    localparam int Z_BIT = 0;
    localparam int N_BIT = 1;
    localparam int C_BIT = 2;

    // Conditional-branch encodings carried on br_type
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_JZ   = 2'b01,
        BR_JN   = 2'b10,
        BR_JC   = 2'b11
    } brType_e;

    // Flag bit tested by a given branch type
    function automatic int brFlagIdx(input logic [1:0] brType);
        int idx;
        idx = Z_BIT;
        unique case (brType)
            BR_JZ:   idx = Z_BIT;
            BR_JN:   idx = N_BIT;
            BR_JC:   idx = C_BIT;
            default: idx = Z_BIT;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/flag_save_lifo.sv
// LIFO of saved condition codes for nested interrupts.
// Ports: clk, rst (async, active-high), push, pop, data_in -> data_out
// (current top, 0 when empty), count, full, empty.
module flag_save_lifo #(
    parameter int FLAG_W     = flag_pkg::FLAG_W,
    parameter int SAVE_DEPTH = 2,
    localparam int CNT_W     = $clog2(SAVE_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] data_in,
    output logic [FLAG_W-1:0] data_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [FLAG_W-1:0] slots [SAVE_DEPTH];
    logic              doPush;
    logic              doPop;

    assign full  = (count == CNT_W'(SAVE_DEPTH));
    assign empty = (count == '0);

    // Pop has precedence; a collision never pushes.
    assign doPop  = pop && !empty;
    assign doPush = push && !pop && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (doPop) begin
            count <= count - CNT_W'(1);
        end else if (doPush) begin
            for (int i = 0; i < SAVE_DEPTH; i++) begin
                if (count == CNT_W'(i)) begin
                    slots[i] <= data_in;
                end
            end
            count <= count + CNT_W'(1);
        end
    end

    // Top of stack is the slot just below count.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < SAVE_DEPTH; i++) begin
            if (count == CNT_W'(i + 1)) begin
                data_out = slots[i];
            end
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Condition-code register with masked ALU writes, branch resolution with
// clear-on-taken, and interrupt save/restore through a nesting LIFO.
// Ports: clk, rst (async, active-high); alu_flags_in, flag_wr_en,
// flag_wr_mask (flag write); br_valid, br_type -> jump_taken (branch);
// int_save, rti_restore (save/restore); ccr_out, save_count, save_full,
// save_empty, err_sticky (registered state).
module flag_unit #(
    parameter int FLAG_W     = flag_pkg::FLAG_W,
    parameter int SAVE_DEPTH = 2,
    localparam int CNT_W     = $clog2(SAVE_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] alu_flags_in,
    input  logic              flag_wr_en,
    input  logic [FLAG_W-1:0] flag_wr_mask,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic [FLAG_W-1:0] ccr_out,
    output logic              jump_taken,
    output logic [CNT_W-1:0]  save_count,
    output logic              save_full,
    output logic              save_empty,
    output logic              err_sticky
);

    import flag_pkg::*;

    logic [FLAG_W-1:0] ccrNext;
    logic [FLAG_W-1:0] lifoTop;
    logic              doRestore;
    logic              errSet;
    logic              testedBit;

    // Branch resolution uses the registered flags only.
    always_comb begin
        testedBit = 1'b0;
        unique case (br_type)
            BR_NONE: testedBit = 1'b0;
            BR_JZ:   testedBit = ccr_out[Z_BIT];
            BR_JN:   testedBit = ccr_out[N_BIT];
            BR_JC:   testedBit = ccr_out[C_BIT];
            default: testedBit = 1'b0;
        endcase
    end

    assign jump_taken = br_valid && testedBit;

    assign doRestore = rti_restore && !save_empty;

    // Layered so later stages win: clear < write < restore.
    always_comb begin
        ccrNext = ccr_out;
        if (jump_taken) begin
            ccrNext[brFlagIdx(br_type)] = 1'b0;
        end
        if (flag_wr_en) begin
            for (int i = 0; i < FLAG_W; i++) begin
                if (flag_wr_mask[i]) begin
                    ccrNext[i] = alu_flags_in[i];
                end
            end
        end
        if (doRestore) begin
            ccrNext = lifoTop;
        end
    end

    // Overflow, underflow, or save/restore in the same cycle.
    assign errSet = (int_save && rti_restore)
                 || (int_save && save_full)
                 || (rti_restore && save_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccr_out    <= '0;
            err_sticky <= 1'b0;
        end else begin
            ccr_out <= ccrNext;
            if (errSet) begin
                err_sticky <= 1'b1;
            end
        end
    end

    // The LIFO ignores a push that collides with a pop.
    flag_save_lifo #(
        .FLAG_W     (FLAG_W),
        .SAVE_DEPTH (SAVE_DEPTH)
    ) uLifo (
        .clk      (clk),
        .rst      (rst),
        .push     (int_save),
        .pop      (rti_restore),
        .data_in  (ccr_out),
        .data_out (lifoTop),
        .count    (save_count),
        .full     (save_full),
        .empty    (save_empty)
    );

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_flag_unit;

    logic       clk;
    logic       rst;
    logic [2:0] alu_flags_in;
    logic       flag_wr_en;
    logic [2:0] flag_wr_mask;
    logic       br_valid;
    logic [1:0] br_type;
    logic       int_save;
    logic       rti_restore;
    logic [2:0] ccr_out;
    logic       jump_taken;
    logic [1:0] save_count;
    logic       save_full;
    logic       save_empty;
    logic       err_sticky;

    int total = 0;
    int bad   = 0;

    flag_unit #(.FLAG_W(3), .SAVE_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_flags_in (alu_flags_in),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_mask (flag_wr_mask),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .int_save     (int_save),
        .rti_restore  (rti_restore),
        .ccr_out      (ccr_out),
        .jump_taken   (jump_taken),
        .save_count   (save_count),
        .save_full    (save_full),
        .save_empty   (save_empty),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_flags_in = 3'b000;
        flag_wr_en   = 1'b0;
        flag_wr_mask = 3'b000;
        br_valid     = 1'b0;
        br_type      = 2'b00;
        int_save     = 1'b0;
        rti_restore  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] d, input logic [2:0] m);
        flag_wr_en   = 1'b1;
        alu_flags_in = d;
        flag_wr_mask = m;
    endtask

    task automatic chkState(input string tag, input logic [2:0] c,
                            input logic [1:0] n, input logic e);
        chk({tag, "_ccr"}, 8'(ccr_out), 8'(c));
        chk({tag, "_cnt"}, 8'(save_count), 8'(n));
        chk({tag, "_err"}, 8'(err_sticky), 8'(e));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        // reset state
        chkState("rst", 3'b000, 2'd0, 1'b0);
        chk("rst_empty", 8'(save_empty), 8'd1);
        chk("rst_full", 8'(save_full), 8'd0);
        chk("rst_jump", 8'(jump_taken), 8'd0);
        rst = 1'b0;

        // full write then JZ taken clears Z
        wr(3'b101, 3'b111);
        tick();
        idle();
        chk("wr101", 8'(ccr_out), 8'h5);
        br_valid = 1'b1;
        br_type  = 2'b01;
        #1;
        chk("jz_taken", 8'(jump_taken), 8'd1);
        tick();
        chk("jz_clear", 8'(ccr_out), 8'h4);
        chk("jz_now_not", 8'(jump_taken), 8'd0);

        // no forwarding of a same-cycle write into the branch
        wr(3'b011, 3'b111);
        #1;
        chk("no_fwd", 8'(jump_taken), 8'd0);
        tick();
        idle();
        chk("wr011", 8'(ccr_out), 8'h3);
        // partial mask only touches C
        wr(3'b100, 3'b100);
        tick();
        idle();
        chk("mask_c", 8'(ccr_out), 8'h7);
        br_type = 2'b11;
        #1;
        chk("jc_no_valid", 8'(jump_taken), 8'd0);
        br_valid = 1'b1;
        br_type  = 2'b00;
        #1;
        chk("br_none", 8'(jump_taken), 8'd0);
        idle();

        // write beats clear on the same bit
        wr(3'b010, 3'b111);
        tick();
        idle();
        br_valid = 1'b1;
        br_type  = 2'b10;
        wr(3'b010, 3'b010);
        #1;
        chk("jn_taken", 8'(jump_taken), 8'd1);
        tick();
        idle();
        chk("wr_wins", 8'(ccr_out), 8'h2);

        // nested save / restore
        wr(3'b101, 3'b111);
        tick();
        idle();
        int_save = 1'b1;
        tick();
        idle();
        chkState("save1", 3'b101, 2'd1, 1'b0);
        wr(3'b000, 3'b111);
        tick();
        idle();
        int_save = 1'b1;
        tick();
        idle();
        chkState("save2", 3'b000, 2'd2, 1'b0);
        chk("save2_full", 8'(save_full), 8'd1);
        rti_restore = 1'b1;
        tick();
        chkState("rti1", 3'b000, 2'd1, 1'b0);
        tick();
        chkState("rti2", 3'b101, 2'd0, 1'b0);
        chk("rti2_empty", 8'(save_empty), 8'd1);
        tick();
        idle();
        chkState("underflow", 3'b101, 2'd0, 1'b1);

        // overflow and collision
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkState("rst2", 3'b000, 2'd0, 1'b0);
        wr(3'b110, 3'b111);
        tick();
        idle();
        int_save = 1'b1;
        tick();
        tick();
        chkState("fill", 3'b110, 2'd2, 1'b0);
        tick();
        idle();
        chkState("overflow", 3'b110, 2'd2, 1'b1);
        wr(3'b011, 3'b111);
        tick();
        idle();
        int_save    = 1'b1;
        rti_restore = 1'b1;
        tick();
        idle();
        chkState("collide", 3'b110, 2'd1, 1'b1);

        // async reset between edges with two saved
        int_save = 1'b1;
        tick();
        idle();
        chk("pre_rst_cnt", 8'(save_count), 8'd2);
        br_valid = 1'b1;
        br_type  = 2'b01;
        #3;
        rst = 1'b1;
        #1;
        chkState("async_rst", 3'b000, 2'd0, 1'b0);
        chk("async_empty", 8'(save_empty), 8'd1);
        chk("async_full", 8'(save_full), 8'd0);
        chk("async_jump", 8'(jump_taken), 8'd0);
        #1;
        rst = 1'b0;
        idle();
        tick();

        // underflow after reset; write still applies
        rti_restore = 1'b1;
        wr(3'b001, 3'b001);
        tick();
        idle();
        chkState("post_rst_uf", 3'b001, 2'd0, 1'b1);

        // save pushes pre-edge value while write updates ccr
        int_save = 1'b1;
        wr(3'b111, 3'b111);
        tick();
        idle();
        chkState("save_wr", 3'b111, 2'd1, 1'b1);
        // restore overrides write and clear
        rti_restore = 1'b1;
        wr(3'b000, 3'b111);
        br_valid = 1'b1;
        br_type  = 2'b01;
        tick();
        idle();
        chkState("rti_over", 3'b001, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter FLAG_W, default 3, SHALL be the condition-code width: bit0 Z, bit1 N, bit2 C.
REQ-002 Parameter SAVE_DEPTH, default 2, SHALL be the number of interrupt flag-save slots (nesting depth).
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 alu_flags_in  in  FLAG_W  flags produced by the ALU for the current instruction.
REQ-006 flag_wr_en  in  1  ALU instruction updates flags this cycle.
REQ-007 flag_wr_mask  in  FLAG_W  per-bit write enable; only set bits are written.
REQ-008 br_valid  in  1  conditional branch in execute this cycle.
REQ-009 br_type  in  2  branch type: 00 none, 01 JZ, 10 JN, 11 JC.
REQ-010 int_save  in  1  interrupt accepted; push current flags.
REQ-011 rti_restore  in  1  RTI executing; pop saved flags.
REQ-012 ccr_out  out  FLAG_W  registered condition-code register.
REQ-013 jump_taken  out  1  conditional branch resolves taken.
REQ-014 save_count  out  log2(SAVE_DEPTH)+1  occupied save slots.
REQ-015 save_full / save_empty  out  1 each  save_count == SAVE_DEPTH / == 0.
REQ-016 err_sticky  out  1  protocol error seen (overflow, underflow or save/restore collision).

Function
REQ-017 jump_taken SHALL be combinational: br_valid AND (ccr_out bit selected by br_type) is 1; br_type 00 SHALL give 0.
REQ-018 jump_taken SHALL use registered ccr_out; a flag write in the same cycle SHALL NOT be forwarded.
REQ-019 On a taken branch, the tested flag SHALL be cleared at the next edge (JZ clears Z, JN clears N, JC clears C).
REQ-020 With flag_wr_en=1, ccr_out bit i SHALL take alu_flags_in[i] at the next edge where flag_wr_mask[i]=1; other bits are held.
REQ-021 If a flag write and a taken-branch clear hit the same bit in one cycle, the flag write SHALL win.
REQ-022 int_save SHALL push ccr_out (pre-edge value) into a LIFO and increment save_count. ccr_out SHALL keep its value, except for same-cycle writes or clears.
REQ-023 rti_restore with save_count>0 SHALL load ccr_out from the LIFO top and decrement save_count. This overrides any same-cycle flag write or branch clear.
REQ-024 int_save when save_full SHALL drop the push, leave the LIFO and count unchanged, and set err_sticky.
REQ-025 rti_restore when save_empty SHALL leave ccr_out, the LIFO and the count unchanged, and set err_sticky. Same-cycle flag writes and clears still apply.
REQ-026 int_save and rti_restore asserted together SHALL execute only the restore, ignore the save, and set err_sticky.
REQ-027 Priority per cycle SHALL be: rst > rti_restore > flag write > branch clear; int_save is evaluated independently under REQ-022/024/026.
REQ-028 All outputs except jump_taken SHALL be registered, with latency of one edge.
REQ-029 err_sticky SHALL be cleared only by rst.

Reset
REQ-030 rst SHALL immediately force ccr_out=0, save_count=0, save_empty=1, save_full=0, err_sticky=0, and clear all LIFO slots to 0.
REQ-031 rst asserted mid-sequence SHALL discard all saved flags; after release, a restore SHALL be treated as underflow.
REQ-032 jump_taken SHALL be 0 during reset, because ccr_out=0.

Structure
REQ-033 A shared package flag_pkg SHALL hold the flag bit indices (Z=0, N=1, C=2), the br_type encodings and the FLAG_W constant.
REQ-034 The LIFO SHALL be one sub-module flag_save_lifo (push, pop, data_in, data_out, count, full, empty), parameterised by FLAG_W and SAVE_DEPTH.
REQ-035 The branch evaluation and the priority merge SHALL live in flag_unit.

Verification
REQ-036 Reset, then write alu_flags_in=101 with mask=111 -> ccr_out=101 after 1 edge; br JZ -> jump_taken=1, then ccr_out=100 next edge.
REQ-037 ccr_out=011, write mask=100 with alu_flags_in=100 -> ccr_out=111; partial mask SHALL NOT disturb Z and N.
REQ-038 ccr_out=010, br JN taken, same cycle write mask=010 data=010 -> ccr_out=010 (write wins over clear).
REQ-039 Save 101, set flags to 000, save 000, restore -> 000, restore -> 101; a third restore -> ccr_out unchanged, err_sticky=1.
REQ-040 With SAVE_DEPTH=2 full, int_save -> save_count stays 2 and err_sticky=1; int_save with rti_restore -> restore only, err_sticky=1.
REQ-041 Assert rst asynchronously between edges with save_count=2 -> all outputs are at reset values before the next edge.
